stream2bram: RTL and testbench

Fabric-side producer for the BRAM frame buffers that the FMC bridge exposes to the MCU. Accepts a valid/ready word stream, writes each frame into the next free BRAM of the bank through the BRAMs' second port, marks that buffer full and signals the MCU. The MCU returns a buffer by writing its release bit, which is pulsed into this block. Runs on the same fmc_clk domain as the FMC bridge.

---
 rtl/stream2bram.sv | 148 ++++++++++++++
 tb/tb_stream2bram.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream2bram.sv
// rtl/stream2bram.sv - valid/ready word stream into a round-robin bank of BRAM frame buffers
module stream2bram #(
    parameter int BRAM_AW = 12,
    parameter int DW      = 32,
    parameter int BRAMS   = 8
) (
    input  logic                     fmc_clk,
    input  logic                     rst,
    input  logic                     s_valid_i,
    input  logic [DW-1:0]            s_data_i,
    input  logic                     s_last_i,
    output logic                     s_ready_o,
    output logic [BRAM_AW-1:0]       bram_a_o,
    output logic [DW-1:0]            bram_do_o,
    output logic [BRAMS-1:0]         bram_en_o,
    output logic                     bram_we_o,
    input  logic [BRAMS-1:0]         release_i,
    output logic [BRAMS-1:0]         full_o,
    output logic                     done_o,
    output logic [$clog2(BRAMS)-1:0] done_idx_o,
    output logic [BRAM_AW:0]         done_len_o,
    output logic                     done_ovf_o
);

    localparam int IW = $clog2(BRAMS);

    typedef enum logic [1:0] {S_WAIT, S_FILL, S_DROP} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        cur_idx_q, cur_idx_d;
    logic [BRAM_AW-1:0]   addr_q, addr_d;
    logic [BRAMS-1:0]     full_q, full_d;
    logic [BRAM_AW-1:0]   bram_a_q, bram_a_d;
    logic [DW-1:0]        bram_do_q, bram_do_d;
    logic [BRAMS-1:0]     bram_en_q, bram_en_d;
    logic                 bram_we_q, bram_we_d;
    logic                 done_q, done_d;
    logic [IW-1:0]        done_idx_q, done_idx_d;
    logic [BRAM_AW:0]     done_len_q, done_len_d;
    logic                 done_ovf_q, done_ovf_d;
    logic [BRAMS-1:0]     set_mask;
    logic [BRAMS-1:0]     cur_onehot;
    logic                 beat;
    logic                 close;

    // State register: all block state, cleared synchronously by rst
    always_ff @(posedge fmc_clk) begin
        if (rst) begin
            state_q    <= S_WAIT;
            cur_idx_q  <= '0;
            addr_q     <= '0;
            full_q     <= '0;
            bram_a_q   <= '0;
            bram_do_q  <= '0;
            bram_en_q  <= '0;
            bram_we_q  <= 1'b0;
            done_q     <= 1'b0;
            done_idx_q <= '0;
            done_len_q <= '0;
            done_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            addr_q     <= addr_d;
            full_q     <= full_d;
            bram_a_q   <= bram_a_d;
            bram_do_q  <= bram_do_d;
            bram_en_q  <= bram_en_d;
            bram_we_q  <= bram_we_d;
            done_q     <= done_d;
            done_idx_q <= done_idx_d;
            done_len_q <= done_len_d;
            done_ovf_q <= done_ovf_d;
        end
    end

    // Next state: accept beats, issue one write per beat, close buffers in strict round-robin
    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        addr_d     = addr_q;
        bram_a_d   = bram_a_q;
        bram_do_d  = bram_do_q;
        bram_en_d  = '0;
        bram_we_d  = 1'b0;
        done_d     = 1'b0;
        done_idx_d = done_idx_q;
        done_len_d = done_len_q;
        done_ovf_d = done_ovf_q;
        set_mask   = '0;
        close      = 1'b0;
        beat       = s_valid_i & s_ready_o;
        cur_onehot = BRAMS'(1) << cur_idx_q;

        case (state_q)
            S_WAIT: begin
                if (!full_q[cur_idx_q]) state_d = S_FILL;
            end
            S_FILL: begin
                if (beat) begin
                    bram_a_d  = addr_q;
                    bram_do_d = s_data_i;
                    bram_en_d = cur_onehot;
                    bram_we_d = 1'b1;
                    if (s_last_i || (&addr_q)) begin
                        // A last beat on the final address is a clean full-length frame
                        close      = 1'b1;
                        done_ovf_d = ~s_last_i;
                        state_d    = s_last_i ? S_WAIT : S_DROP;
                    end else begin
                        addr_d = addr_q + BRAM_AW'(1);
                    end
                end
            end
            S_DROP: begin
                if (beat && s_last_i) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase

        if (close) begin
            set_mask   = cur_onehot;
            done_d     = 1'b1;
            done_idx_d = cur_idx_q;
            done_len_d = {1'b0, addr_q} + (BRAM_AW+1)'(1);
            cur_idx_d  = cur_idx_q + IW'(1);
            addr_d     = '0;
        end

        // Set wins over a release of the same buffer in the same cycle
        full_d = (full_q & ~release_i) | set_mask;
    end

    // Outputs: s_ready decoded from the state register only, the rest straight from registers
    always_comb begin
        s_ready_o  = (state_q == S_FILL) || (state_q == S_DROP);
        bram_a_o   = bram_a_q;
        bram_do_o  = bram_do_q;
        bram_en_o  = bram_en_q;
        bram_we_o  = bram_we_q;
        full_o     = full_q;
        done_o     = done_q;
        done_idx_o = done_idx_q;
        done_len_o = done_len_q;
        done_ovf_o = done_ovf_q;
    end

endmodule

// File: tb/tb_stream2bram.sv
// tb/tb_stream2bram.sv - scoreboard bench for stream2bram
module tb_stream2bram;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = 8;

    logic            fmc_clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [AW-1:0]   bram_a;
    logic [DW-1:0]   bram_do;
    logic [NB-1:0]   bram_en;
    logic            bram_we;
    logic [NB-1:0]   rel = '0;
    logic [NB-1:0]   full;
    logic            done;
    logic [2:0]      done_idx;
    logic [AW:0]     done_len;
    logic            done_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct { int idx; int addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int idx; int len; logic ovf; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    // bench-side expectation of where the next word goes
    int  m_idx = 0;
    int  m_addr = 0;
    bit  m_drop = 0;

    stream2bram #(.BRAM_AW(AW), .DW(DW), .BRAMS(NB)) dut (
        .fmc_clk(fmc_clk), .rst(rst),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(s_ready),
        .bram_a_o(bram_a), .bram_do_o(bram_do), .bram_en_o(bram_en), .bram_we_o(bram_we),
        .release_i(rel), .full_o(full), .done_o(done), .done_idx_o(done_idx),
        .done_len_o(done_len), .done_ovf_o(done_ovf)
    );

    always #5 fmc_clk = ~fmc_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every write and every done pulse with the queued expectation
    always @(negedge fmc_clk) begin
        if (bram_we) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", bram_a, bram_do);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("write_en", 64'(bram_en), 64'(8'h1 << w.idx));
                check("write_addr", 64'(bram_a), 64'(w.addr));
                check("write_data", 64'(bram_do), 64'(w.data));
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got idx %0d len %0d, expected none", done_idx, done_len);
            end else begin
                dn_t d;
                d = dq.pop_front();
                check("done_idx", 64'(done_idx), 64'(d.idx));
                check("done_len", 64'(done_len), 64'(d.len));
                check("done_ovf", 64'(done_ovf), 64'(d.ovf));
            end
        end
    end

    // Push expectations for a beat that is being accepted
    task automatic expect_beat(input logic [DW-1:0] data, input bit last);
        if (m_drop) begin
            if (last) m_drop = 0;
        end else begin
            wq.push_back('{m_idx, m_addr, data});
            if (last || m_addr == (1 << AW) - 1) begin
                dq.push_back('{m_idx, m_addr + 1, !last});
                m_idx = (m_idx + 1) % NB;
                m_addr = 0;
                m_drop = !last;
            end else begin
                m_addr++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted
    task automatic send_word(input logic [DW-1:0] data, input bit last, input logic [NB-1:0] r);
        int n = 0;
        s_valid = 1'b1; s_data = data; s_last = last;
        while (!s_ready && n < 200) begin
            @(negedge fmc_clk); n++;
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got s_ready 0, expected 1 within 200 cycles");
        end else begin
            rel = r;
            expect_beat(data, last);
            @(negedge fmc_clk);
            rel = '0;
        end
    endtask

    task automatic send_frame(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) send_word(base + DW'(i), i == n - 1, '0);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic pulse_release(input logic [NB-1:0] r);
        rel = r;
        @(negedge fmc_clk);
        rel = '0;
    endtask

    task automatic do_reset(input string tag);
        s_valid = 1'b0; s_last = 1'b0; rst = 1'b1;
        repeat (3) @(negedge fmc_clk);
        check({tag, "_s_ready"}, 64'(s_ready), 0);
        check({tag, "_bram_out"}, {bram_a, bram_do, bram_en, bram_we}, 0);
        check({tag, "_full"}, 64'(full), 0);
        check({tag, "_done"}, {done, done_idx, done_len, done_ovf}, 0);
        rst = 1'b0;
        m_idx = 0; m_addr = 0; m_drop = 0;
    endtask

    initial begin
        @(negedge fmc_clk);
        do_reset("reset");

        // reset mid-frame: 3 of 6 words written, then abandoned
        send_word(32'h10, 0, '0);
        send_word(32'h11, 0, '0);
        send_word(32'h12, 0, '0);
        do_reset("midreset");

        // single frame to buffer 0
        send_frame(4, 32'hA0);
        repeat (2) @(negedge fmc_clk);
        check("single_full", 64'(full), 64'h01);

        // buffer 1, then buffer 2 closes with release[2] in the same cycle
        send_frame(2, 32'hB0);
        send_word(32'hC0, 1, 8'h04);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge fmc_clk);
        check("rel_set_same_cycle_full", 64'(full), 64'h07);
        pulse_release(8'h20);
        check("rel_not_full_ignored", 64'(full), 64'h07);
        pulse_release(8'h07);
        check("multi_release", 64'(full), 64'h00);

        // overflow into buffer 3, then exact 16-word frame into buffer 4
        send_frame(20, 32'h100);
        send_frame(16, 32'h200);
        repeat (2) @(negedge fmc_clk);
        check("ovf_full", 64'(full), 64'h18);

        // back-pressure: 8 one-word frames fill the bank, the 9th waits for release[0]
        do_reset("bp_reset");
        for (int i = 0; i < NB; i++) send_frame(1, 32'h300 + DW'(i));
        s_valid = 1'b1; s_data = 32'h3FF; s_last = 1'b1;
        repeat (10) @(negedge fmc_clk);
        check("bp_full", 64'(full), 64'hFF);
        check("bp_ready_low", 64'(s_ready), 0);
        pulse_release(8'h01);
        check("refill_ready_still_low", 64'(s_ready), 0);
        @(negedge fmc_clk);
        check("refill_ready_high", 64'(s_ready), 1);
        send_word(32'h3FF, 1, '0);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(negedge fmc_clk);
        check("bp_full_again", 64'(full), 64'hFF);

        check("writes_drained", 64'(wq.size()), 0);
        check("dones_drained", 64'(dq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
